// File: rtl/usb_ulpi_token_rx.sv
// usb_ulpi_token_rx: ULPI receive decoder separating RX CMDs from packet bytes and emitting token/SOF events.
// Define USB_RX_CRC5_CHECK_EN to reject tokens whose CRC5 residual is wrong.
module usb_ulpi_token_rx #(
    parameter int FILTER_ADDR = 0
) (
    input  logic        USB_CLKIN,
    input  logic        RST,
    input  logic [7:0]  USB_DATA_I,
    input  logic        USB_DIR,
    input  logic        USB_NXT,
    input  logic [6:0]  DEV_ADDR,
    output logic        TOKEN_VALID,
    output logic [3:0]  TOKEN_PID,
    output logic [6:0]  TOKEN_ADDR,
    output logic [3:0]  TOKEN_ENDP,
    output logic        SOF_VALID,
    output logic [10:0] SOF_FRAME,
    output logic [1:0]  LINESTATE,
    output logic        RX_ACTIVE,
    output logic        RX_ERR
);
    typedef enum logic [2:0] {S_IDLE, S_B1, S_B2, S_WAIT_END, S_DROP, S_EMIT} state_t;
`ifdef USB_RX_CRC5_CHECK_EN
    localparam int B2W = 8;
`else
    localparam int B2W = 3;
`endif
    state_t         r_state;
    logic           r_dir_d;
    logic           r_lock;
    logic [3:0]     r_pid;
    logic [7:0]     r_b1;
    logic [B2W-1:0] r_b2;
    logic           w_live;
    logic           w_pkt;
    logic           w_cmd;
    logic [1:0]     w_ev;
    logic           w_eop;
    logic           w_cmd_err;
    logic           w_pid_ok;
    logic           w_is_tok;
    logic           w_is_sof;
    logic           w_addr_hit;
    logic           w_crc_ok;

    // r_lock keeps bytes ignored after reset until the bus has been turned back to the link
    assign w_live     = USB_DIR & r_dir_d & ~r_lock;
    assign w_pkt      = w_live & USB_NXT;
    assign w_cmd      = w_live & ~USB_NXT;
    assign w_ev       = USB_DATA_I[5:4];
    assign w_eop      = ~USB_DIR | (w_cmd & ~w_ev[0]);
    assign w_cmd_err  = w_cmd & (w_ev == 2'b11);
    assign w_pid_ok   = USB_DATA_I[7:4] == ~USB_DATA_I[3:0];
    assign w_is_tok   = USB_DATA_I[1:0] == 2'b01;
    assign w_is_sof   = r_pid == 4'b0101;
    assign w_addr_hit = (FILTER_ADDR == 0) || (r_b1[6:0] == DEV_ADDR);

`ifdef USB_RX_CRC5_CHECK_EN
    function automatic logic [4:0] crc5(input logic [15:0] d);
        logic [4:0] c;
        c = 5'h1f;
        for (int i = 0; i < 16; i++) c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'b00101 : 5'b00000);
        return c;
    endfunction
    assign w_crc_ok = crc5({r_b2, r_b1}) == 5'b01100;
`else
    assign w_crc_ok = 1'b1;
`endif

    always_ff @(posedge USB_CLKIN) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_dir_d     <= 1'b0;
            r_lock      <= 1'b1;
            r_pid       <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            TOKEN_VALID <= 1'b0;
            TOKEN_PID   <= '0;
            TOKEN_ADDR  <= '0;
            TOKEN_ENDP  <= '0;
            SOF_VALID   <= 1'b0;
            SOF_FRAME   <= '0;
            LINESTATE   <= '0;
            RX_ACTIVE   <= 1'b0;
            RX_ERR      <= 1'b0;
        end else begin
            r_dir_d     <= USB_DIR;
            r_lock      <= r_lock & USB_DIR;
            TOKEN_VALID <= 1'b0;
            SOF_VALID   <= 1'b0;
            RX_ERR      <= 1'b0;
            if (w_cmd) begin
                LINESTATE <= USB_DATA_I[1:0];
                RX_ACTIVE <= w_ev[0];
            end
            case (r_state)
                S_IDLE, S_EMIT: begin
                    if (w_pkt) begin
                        r_pid   <= USB_DATA_I[3:0];
                        r_state <= (w_pid_ok && w_is_tok) ? S_B1 : S_DROP;
                        RX_ERR  <= ~w_pid_ok;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_B1, S_B2: begin
                    if (w_cmd_err) begin
                        RX_ERR  <= 1'b1;
                        r_state <= S_DROP;
                    end else if (w_eop) begin
                        RX_ERR  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_pkt && r_state == S_B1) begin
                        r_b1    <= USB_DATA_I;
                        r_state <= S_B2;
                    end else if (w_pkt) begin
                        r_b2    <= USB_DATA_I[B2W-1:0];
                        r_state <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    // Events are registered on the end-of-packet edge so they coincide with EMIT
                    if (w_cmd_err || w_pkt) begin
                        RX_ERR  <= 1'b1;
                        r_state <= S_DROP;
                    end else if (w_eop) begin
                        r_state <= S_EMIT;
                        if (!w_crc_ok) begin
                            RX_ERR <= 1'b1;
                        end else if (w_is_sof) begin
                            SOF_VALID <= 1'b1;
                            SOF_FRAME <= {r_b2[2:0], r_b1};
                        end else if (w_addr_hit) begin
                            TOKEN_VALID <= 1'b1;
                            TOKEN_PID   <= r_pid;
                            TOKEN_ADDR  <= r_b1[6:0];
                            TOKEN_ENDP  <= {r_b2[2:0], r_b1[7]};
                        end
                    end
                end
                S_DROP: begin
                    if (w_cmd_err) RX_ERR <= 1'b1;
                    else if (w_eop) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/usb_ulpi_token_rx.md
# usb_ulpi_token_rx

Receive-side ULPI link decoder for the USB audio card. It watches the PHY → link byte stream on USB_CLKIN and separates RX CMD bytes from packet bytes. It decodes USB token packets (OUT, IN, SETUP, SOF) and presents them as single-cycle events to the handshake/transmit logic that drives the bus back to the host. It is the receive counterpart of the handshake multiplexer and sits beside it under the top level, sharing the PHY pins.

## Interface
Parameters:
- FILTER_ADDR, default 0: when 1, OUT/IN/SETUP tokens whose address differs from DEV_ADDR are discarded. SOF is never filtered.

Ports:
- USB_CLKIN  in  1  60 MHz PHY clock; the only clock.
- RST  in  1  Synchronous, active-high reset.
- USB_DATA_I  in  8  PHY data bus, input side; tristate resolved at top.
- USB_DIR  in  1  ULPI DIR; 1 = PHY drives the bus.
- USB_NXT  in  1  ULPI NXT.
- DEV_ADDR  in  7  Device address used by the filter.
- TOKEN_VALID  out  1  One-cycle pulse: OUT/IN/SETUP token accepted.
- TOKEN_PID  out  4  PID[3:0] of the last accepted token.
- TOKEN_ADDR  out  7  Address field.
- TOKEN_ENDP  out  4  Endpoint field.
- SOF_VALID  out  1  One-cycle pulse: SOF accepted.
- SOF_FRAME  out  11  Frame number of the last SOF.
- LINESTATE  out  2  RX CMD bits[1:0], held between RX CMDs.
- RX_ACTIVE  out  1  RX CMD RxActive, registered.
- RX_ERR  out  1  One-cycle pulse on a malformed or aborted packet.

## Operation
- Turnaround: the first cycle with DIR=1 after DIR=0 is ignored.
- Byte classification, with DIR=1 and past turnaround:
  - NXT=1: packet byte.
  - NXT=0: RX CMD. LINESTATE is set from bits[1:0]. Bits[5:4] give the event: 01 = RxActive, 11 = RxError, 00/10 = inactive.
- End of packet: the first cycle with DIR=0, or an RX CMD with the event not equal to 01 or 11.
- States:
  - IDLE → PID on the first packet byte.
  - In PID: if PID[7:4] is not ~PID[3:0], go to DROP and pulse RX_ERR. If the PID is a token (0001 OUT, 1001 IN, 1101 SETUP, 0101 SOF), go to B1. Any other PID goes to DROP with no error.
  - B1 → B2 on the next packet byte; B2 → WAIT_END on the next packet byte.
  - WAIT_END: end of packet → EMIT. Any further packet byte → DROP with RX_ERR.
  - DROP: stays until end of packet, then IDLE.
  - EMIT: evaluates the checks, pulses the outputs, then IDLE.
- Field extraction:
  - B1[6:0] is the address; ENDP is {B2[2:0], B1[7]}; CRC5 is B2[7:3].
  - SOF_FRAME is {B2[2:0], B1}.
- End of packet while in PID, B1 or B2 (short token) → pulse RX_ERR, go to IDLE, emit no token.
- An RxError RX CMD in any non-IDLE state → pulse RX_ERR, go to DROP.
- TOKEN_* and SOF_FRAME update only on an accepted event and otherwise hold their value.
- Filter: with FILTER_ADDR=1, an address mismatch gives a silent discard, with no RX_ERR.

## Timing
- Reset: state IDLE; all outputs 0, including LINESTATE=00 and the TOKEN/SOF fields.
- RST mid-packet returns to IDLE with no pulse. Bytes that follow, up to the next DIR=0, are treated as DROP.
- TOKEN_VALID / SOF_VALID are asserted exactly one cycle after the end-of-packet cycle. They last 1 cycle.
- RX_ERR is registered and asserted the cycle after the detecting byte or event.
- LINESTATE and RX_ACTIVE update the cycle after the RX CMD byte.
- A DIR fall in the same cycle as a packet byte: the byte is ignored (bus turned). End of packet wins.
- Back-to-back packets separated only by RX CMDs are supported. EMIT takes 1 cycle, and a new PID may arrive in that same cycle. A byte arriving during EMIT is captured as the next PID.

## Configuration
- USB_RX_CRC5_CHECK_EN defined:
  - Shift the 16 bits of B1 then B2, LSB first, through CRC5 (x^5+x^2+1) with initial value 11111.
  - Accept only if the residual equals 01100. On mismatch: RX_ERR pulse in EMIT and no token.
- Not defined: no CRC logic; the CRC field is ignored and every well-formed token is accepted.

## Test plan
- SETUP token: bytes 0x2D, 0x00, 0x10, then DIR falls → TOKEN_VALID one cycle later with PID=1101, ADDR=0, ENDP=0. RX_ERR stays 0.
- PID complement error: byte 0x2C, 0x00, 0x10 → RX_ERR pulse after the PID byte; no TOKEN_VALID.
- Short token: bytes 0x69, 0x00, then DIR falls → RX_ERR pulse; no TOKEN_VALID; the next valid 0xE1,0x00,0x10 yields PID=0001.
- With FILTER_ADDR=1 and DEV_ADDR=5: IN token to addr 0 (0x69,0x00,0x10) → no pulse and no RX_ERR. SOF with a valid CRC → SOF_VALID with the correct SOF_FRAME.
- With the CRC macro on, 0x2D,0x00,0x18 → RX_ERR, no token. With the macro off → TOKEN_VALID, ENDP=0.
- RX CMD 0x1D (RxActive, LINESTATE=01) → LINESTATE=01, RX_ACTIVE=1 next cycle. RST asserted mid-token → all outputs 0 and no pulse.
